// File: rtl/noobs_cpu_pkg.sv
// noobs_cpu_pkg: opcodes, sub-op/condition codes, FSM states and instruction length for the noobs CPU.
package noobs_cpu_pkg;
    localparam logic [3:0] OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_UNA = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8, OP_LD  = 4'h9, OP_ST  = 4'hA, OP_LDR = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC, OP_JCC = 4'hD, OP_CMP = 4'hE, OP_HLT = 4'hF;
    localparam logic [1:0] UN_NOT = 2'd0, UN_SHL = 2'd1, UN_SHR = 2'd2, UN_CLR = 2'd3;
    localparam logic [1:0] CC_Z = 2'd0, CC_NZ = 2'd1, CC_C = 2'd2, CC_NC = 2'd3;
    typedef enum logic [2:0] {FETCH_A, FETCH_D, EXEC, MEM_RA, MEM_RD, MEM_W, HALT} state_t;
    function automatic logic [1:0] instr_len(input logic [3:0] op);
        return (op == OP_LDI) ? 2'd2 :
               (op == OP_LD || op == OP_ST || op == OP_JMP || op == OP_JCC) ? 2'd3 : 2'd1;
    endfunction
endpackage

// File: rtl/noobs_alu.sv
// noobs_alu: combinational 8-bit ALU; bit 8 of the internal result is the carry/borrow flag.
module noobs_alu
    import noobs_cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    input  logic [1:0] subop,
    output logic [7:0] result,
    output logic       z,
    output logic       n,
    output logic       c
);
    logic [8:0] sum, diff, una, r9;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign una  = (subop == UN_NOT) ? {1'b0, ~a} :
                  (subop == UN_SHL) ? {a[7], a[6:0], 1'b0} :
                  (subop == UN_SHR) ? {a[0], 1'b0, a[7:1]} : 9'd0;
    assign r9 = (op == OP_ADD) ? sum :
                (op == OP_SUB || op == OP_CMP) ? diff :
                (op == OP_AND) ? {1'b0, a & b} :
                (op == OP_OR)  ? {1'b0, a | b} :
                (op == OP_XOR) ? {1'b0, a ^ b} :
                (op == OP_UNA) ? una : 9'd0;
    assign result = r9[7:0];
    assign c      = r9[8];
    assign z      = (r9[7:0] == 8'd0);
    assign n      = r9[7];
endmodule

// File: rtl/noobs_cpu_core.sv
// noobs_cpu_core: 8-bit multi-cycle Harvard CPU; register file, PC and fetch/execute FSM.
// All memory strobes are registered from the next state so they never glitch.
module noobs_cpu_core
    import noobs_cpu_pkg::*;
#(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int          NREGS    = 4
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [7:0]  i_data,
    output logic [11:0] i_addr,
    inout  logic [7:0]  m_data,
    output logic [11:0] m_addr,
    output logic        m_rd,
    output logic        m_wr,
    output logic        m_en,
    output logic        halted
);
    state_t      state, state_nxt;
    logic [11:0] pc, mem_addr_nxt;
    logic [7:0]  regs [NREGS];
    logic [7:0]  ir0, ir1, ir2, wdata, alu_res;
    logic [1:0]  byte_idx, rd, rs;
    logic [3:0]  op, cur_op;
    logic        z_f, n_f, c_f, alu_z, alu_n, alu_c, last, take, alu_wr;
    logic        unused_ok;

    assign op        = ir0[7:4];
    assign rd        = ir0[3:2];
    assign rs        = ir0[1:0];
    assign cur_op    = (byte_idx == 2'd0) ? i_data[7:4] : op;
    assign last      = (byte_idx + 2'd1) == instr_len(cur_op);
    assign take      = (rd == CC_Z) ? z_f : (rd == CC_NZ) ? !z_f : (rd == CC_C) ? c_f : !c_f;
    assign alu_wr    = (op >= OP_ADD) && (op <= OP_UNA);
    assign i_addr    = pc;
    assign m_data    = (m_en && m_wr) ? wdata : 8'bz;
    assign unused_ok = ^{n_f, ir1[7:4]};

    noobs_alu u_alu (
        .a(regs[rd]), .b(regs[rs]), .op(op), .subop(rs),
        .result(alu_res), .z(alu_z), .n(alu_n), .c(alu_c)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= FETCH_A;
        else         state <= state_nxt;
    end

    // LD/ST go straight from their last fetch byte to the memory cycle; LDR needs EXEC to read R[rs].
    always_comb begin
        state_nxt    = state;
        mem_addr_nxt = (state == EXEC) ? {4'h0, regs[rs]} : {ir1[3:0], i_data};
        case (state)
            FETCH_A: state_nxt = FETCH_D;
            FETCH_D: state_nxt = !last ? FETCH_A : (cur_op == OP_LD) ? MEM_RA :
                                 (cur_op == OP_ST) ? MEM_W : EXEC;
            EXEC:    state_nxt = (op == OP_LDR) ? MEM_RA : (op == OP_HLT) ? HALT : FETCH_A;
            MEM_RA:  state_nxt = MEM_RD;
            MEM_RD:  state_nxt = FETCH_A;
            MEM_W:   state_nxt = FETCH_A;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH_A;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pc       <= RESET_PC;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            {z_f, n_f, c_f} <= '0;
            {ir0, ir1, ir2} <= '0;
            byte_idx <= '0;
            {m_en, m_rd, m_wr, halted} <= '0;
            m_addr   <= '0;
            wdata    <= '0;
        end else begin
            m_rd   <= (state_nxt == MEM_RA);
            m_wr   <= (state_nxt == MEM_W);
            m_en   <= (state_nxt == MEM_RA) || (state_nxt == MEM_W);
            halted <= (state_nxt == HALT);
            if (state_nxt == MEM_RA || state_nxt == MEM_W) begin
                m_addr <= mem_addr_nxt;
                wdata  <= regs[rd];
            end
            if (state == FETCH_D) begin
                if (byte_idx == 2'd0) ir0 <= i_data;
                if (byte_idx == 2'd1) ir1 <= i_data;
                if (byte_idx == 2'd2) ir2 <= i_data;
                pc       <= pc + 12'd1;
                byte_idx <= last ? 2'd0 : byte_idx + 2'd1;
            end
            if (state == EXEC) begin
                if (alu_wr) regs[rd] <= alu_res;
                if (alu_wr || op == OP_CMP) {z_f, n_f, c_f} <= {alu_z, alu_n, alu_c};
                if (op == OP_MOV) regs[rd] <= regs[rs];
                if (op == OP_LDI) regs[rd] <= ir1;
                if (op == OP_JMP || (op == OP_JCC && take)) pc <= {ir1[3:0], ir2};
            end
            if (state == MEM_RD) regs[rd] <= m_data;
        end
    end
endmodule

// File: tb/tb_noobs_cpu_core.sv
// tb_noobs_cpu_core: table-driven ALU vectors plus hand-written load, branch, reset and wrap sequences.
module tb_noobs_cpu_core;
    logic        clk = 1'b0, reset_ = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic [11:0] i_addr, m_addr;
    wire  [7:0]  m_data;
    logic        m_rd, m_wr, m_en, halted;

    logic [7:0]  imem [4096];
    logic [7:0]  dmem [4096];
    logic [7:0]  rd_q = 8'h00, pre_data = 8'h00;
    logic [11:0] pre_addr = 12'h000;
    logic        rd_valid = 1'b0, pre_we = 1'b0, mon_clr = 1'b0, prev_rd = 1'b0;
    int          rd_cycles = 0, rd_rises = 0, wr_cycles = 0, both_hi = 0;
    int          n_vec = 0, n_bad = 0;
    logic [7:0]  pbuf [$];

    typedef struct {
        logic [7:0] opb, a, b, res;
        logic       c, z;
    } vec_t;
    vec_t vt [14];

    noobs_cpu_core dut (
        .clk(clk), .reset_(reset_), .i_data(i_data), .i_addr(i_addr),
        .m_data(m_data), .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr),
        .m_en(m_en), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) i_data <= imem[i_addr];

    always @(posedge clk) begin
        if (pre_we) dmem[pre_addr] <= pre_data;
        else if (m_en && m_wr) dmem[m_addr] <= m_data;
        rd_q     <= dmem[m_addr];
        rd_valid <= m_en && m_rd;
    end
    assign m_data = rd_valid ? rd_q : 8'hzz;

    always @(negedge clk) begin
        if (m_rd && m_wr) both_hi <= both_hi + 1;
        if (mon_clr) begin
            rd_cycles <= 0;
            rd_rises  <= 0;
            wr_cycles <= 0;
        end else begin
            if (m_rd) rd_cycles <= rd_cycles + 1;
            if (m_rd && !prev_rd) rd_rises <= rd_rises + 1;
            if (m_wr) wr_cycles <= wr_cycles + 1;
        end
        prev_rd <= m_rd;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic begin_prog();
        reset_ = 1'b0;
        for (int i = 0; i < 4096; i++) imem[i] = 8'h00;
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic load(input int base);
        for (int i = 0; i < pbuf.size(); i++) imem[base + i] = pbuf[i];
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic go();
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    task automatic wait_halt(input string name, input int bound);
        int n;
        n = 0;
        while (!halted && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(halted), 1);
    endtask

    initial begin
        int n, m, k;
        vt[0]  = '{8'h21, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
        vt[1]  = '{8'h21, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vt[2]  = '{8'h31, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        vt[3]  = '{8'h31, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1};
        vt[4]  = '{8'h41, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vt[5]  = '{8'h51, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0};
        vt[6]  = '{8'h61, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1};
        vt[7]  = '{8'h70, 8'h0F, 8'h99, 8'hF0, 1'b0, 1'b0};
        vt[8]  = '{8'h71, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0};
        vt[9]  = '{8'h72, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1};
        vt[10] = '{8'h73, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1};
        vt[11] = '{8'hE1, 8'h30, 8'h40, 8'h30, 1'b1, 1'b0};
        vt[12] = '{8'h11, 8'h12, 8'h34, 8'h34, 1'b0, 1'b0};
        vt[13] = '{8'h00, 8'h77, 8'h55, 8'h77, 1'b0, 1'b0};

        // Reset state before any program runs.
        begin_prog();
        #1;
        chk("rst_i_addr", int'(i_addr), 0);
        chk("rst_strobes", int'({m_en, m_rd, m_wr}), 0);
        chk("rst_halted", int'(halted), 0);

        // Each vector: LDI R0,a; LDI R1,b; <op>; ST R0,[100]; C and Z captured into [101]/[102].
        for (int v = 0; v < 14; v++) begin
            begin_prog();
            pbuf = '{8'h80, vt[v].a, 8'h84, vt[v].b, vt[v].opb, 8'hA0, 8'h01, 8'h00,
                     8'h88, 8'h00, 8'hDC, 8'h00, 8'h0F, 8'h88, 8'h01,
                     8'h8C, 8'h00, 8'hD4, 8'h00, 8'h16, 8'h8C, 8'h01,
                     8'hA8, 8'h01, 8'h01, 8'hAC, 8'h01, 8'h02, 8'hF0};
            load(0);
            poke(12'h100, 8'hEE);
            poke(12'h101, 8'hEE);
            poke(12'h102, 8'hEE);
            go();
            wait_halt($sformatf("v%0d_halt", v), 400);
            chk($sformatf("v%0d_result", v), int'(dmem[12'h100]), int'(vt[v].res));
            chk($sformatf("v%0d_carry", v), int'(dmem[12'h101]), int'(vt[v].c));
            chk($sformatf("v%0d_zero", v), int'(dmem[12'h102]), int'(vt[v].z));
        end

        // Load / indirect load, flags must survive the loads (Z set by SUB first).
        begin_prog();
        pbuf = '{8'h30, 8'h98, 8'h00, 8'h05, 8'h8C, 8'h05, 8'hB7,
                 8'hA8, 8'h01, 8'h00, 8'hA4, 8'h01, 8'h01,
                 8'hD4, 8'h00, 8'h13, 8'hAC, 8'h01, 8'h02, 8'hF0};
        load(0);
        poke(12'h005, 8'h5A);
        poke(12'h100, 8'hEE);
        poke(12'h101, 8'hEE);
        poke(12'h102, 8'hEE);
        go();
        wait_halt("ld_halt", 400);
        chk("ld_r2", int'(dmem[12'h100]), 8'h5A);
        chk("ldr_r1", int'(dmem[12'h101]), 8'h5A);
        chk("ld_flags_kept", int'(dmem[12'h102]), 8'h05);
        chk("ld_rd_pulses", rd_rises, 2);
        chk("ld_rd_cycles", rd_cycles, 2);

        // Branch: JZ taken, fall-through store must never happen.
        begin_prog();
        pbuf = '{8'h80, 8'h01, 8'h30, 8'hD0, 8'h00, 8'h20, 8'hA0, 8'h02, 8'h01, 8'hF0};
        load(0);
        pbuf = '{8'hA0, 8'h02, 8'h00, 8'hF0};
        load(12'h020);
        poke(12'h200, 8'hEE);
        poke(12'h201, 8'hEE);
        go();
        wait_halt("br_halt", 400);
        chk("br_target_st", int'(dmem[12'h200]), 8'h00);
        chk("br_no_fallthru", int'(dmem[12'h201]), 8'hEE);
        chk("br_wr_cycles", wr_cycles, 1);

        // Shift / compare: JNZ 0x000 must not be taken, PC frozen after HLT.
        begin_prog();
        pbuf = '{8'h80, 8'h81, 8'h71, 8'hA0, 8'h03, 8'h00, 8'hE0, 8'hD4, 8'h00, 8'h00, 8'hF0};
        load(0);
        poke(12'h300, 8'hEE);
        go();
        wait_halt("sc_halt", 400);
        chk("sc_shl", int'(dmem[12'h300]), 8'h02);
        chk("sc_pc_halt", int'(i_addr), 12'h00B);
        repeat (5) @(negedge clk);
        chk("sc_pc_frozen", int'(i_addr), 12'h00B);
        chk("sc_no_strobe", int'({m_en, m_rd, m_wr}), 0);

        // Asynchronous reset: clears halted, then aborts a store in its MEM_W cycle.
        begin_prog();
        pbuf = '{8'h80, 8'h77, 8'hA0, 8'h01, 8'h50, 8'hF0};
        load(0);
        poke(12'h150, 8'h11);
        go();
        wait_halt("rs_halt", 400);
        chk("rs_store", int'(dmem[12'h150]), 8'h77);
        @(negedge clk);
        #2 reset_ = 1'b0;
        #1;
        chk("rs_halted_clr", int'(halted), 0);
        chk("rs_i_addr", int'(i_addr), 0);
        poke(12'h150, 8'h11);
        go();
        n = 0;
        while (!m_wr && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rs_st_seen", int'(m_wr), 1);
        chk("rs_st_data", int'(m_data), 8'h77);
        chk("rs_st_addr", int'(m_addr), 12'h150);
        #1 reset_ = 1'b0;
        #1;
        chk("rs_abort_strobes", int'({m_en, m_rd, m_wr}), 0);
        chk("rs_abort_pc", int'(i_addr), 0);
        repeat (3) @(negedge clk);
        chk("rs_st_dropped", int'(dmem[12'h150]), 8'h11);

        // JMP 0xFFF onto a NOP, then PC wraps to 0x000.
        begin_prog();
        pbuf = '{8'hC0, 8'h0F, 8'hFF};
        load(0);
        go();
        n = 0;
        while (i_addr != 12'hFFF && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("jmp_latency", n, 7);
        m = 0;
        while (i_addr == 12'hFFF && m < 20) begin
            @(negedge clk);
            m++;
        end
        chk("nop_fetch_cycles", m, 2);
        chk("wrap_addr", int'(i_addr), 0);
        k = 0;
        while (i_addr == 12'h000 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("wrap_hold_cycles", k, 3);
        chk("after_wrap_addr", int'(i_addr), 1);
        reset_ = 1'b0;

        chk("rd_wr_overlap", both_hi, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
